universal_shift_reg: RTL and testbench

//  Parametrised successor to the plain 8-bit load/hold register. Provides a

---
 rtl/shreg_pkg.sv | 22 ++
 rtl/shreg_burst_ctrl.sv | 84 ++++++++
 rtl/universal_shift_reg.sv | 81 ++++++++
 tb/tb_universal_shift_reg.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shreg_pkg.sv
// Shared encodings for the universal shift register:
// single-step modes, burst FSM states and rotate directions.
package shreg_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_ROL   = 3'b100;
  localparam logic [2:0] MODE_ROR   = 3'b101;
  localparam logic [2:0] MODE_ASR   = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shreg_burst_ctrl.sv
// Burst-rotate sequencer: latches direction and length,
// strobes one rotate per cycle and pulses done at the end.
module shreg_burst_ctrl
  import shreg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          start,
  input  logic          dir,
  input  logic [CW-1:0] amt,
  output logic          busy,
  output logic          done,
  output logic          step,
  output logic          step_dir
);

  localparam logic [CW-1:0] AMT_MAX = CW'(WIDTH);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic          done_q, done_d;
  logic [CW-1:0] amt_c;

  // Lengths beyond WIDTH collapse to one full turn.
  assign amt_c = (amt > AMT_MAX) ? AMT_MAX : amt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= DIR_LEFT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable && start) begin
          if (amt_c == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = SHIFT;
            cnt_d   = amt_c;
            dir_d   = dir;
          end
        end
      end
      SHIFT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy     = (state_q == SHIFT);
    step     = (state_q == SHIFT);
    step_dir = dir_q;
    done     = done_q;
  end

endmodule

// File: rtl/universal_shift_reg.sv
// WIDTH-bit register with load, single-step shift/rotate
// modes and a multi-cycle burst-rotate engine.
module universal_shift_reg
  import shreg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [2:0]             mode,
  input  logic [WIDTH-1:0]       D,
  input  logic                   sin_l,
  input  logic                   sin_r,
  input  logic                   start,
  input  logic                   dir,
  input  logic [$clog2(WIDTH):0] amt,
  output logic [WIDTH-1:0]       Q,
  output logic                   sout_msb,
  output logic                   sout_lsb,
  output logic                   zero,
  output logic                   busy,
  output logic                   done
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rol, ror;
  logic             step, step_dir;

  shreg_burst_ctrl #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .start    (start),
    .dir      (dir),
    .amt      (amt),
    .busy     (busy),
    .done     (done),
    .step     (step),
    .step_dir (step_dir)
  );

  assign rol = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign ror = {q_q[0], q_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q_q <= RESET_VAL;
    else        q_q <= q_d;
  end

  // A running burst owns the datapath; start in idle masks mode.
  always_comb begin
    q_d = q_q;
    if (step) begin
      q_d = (step_dir == DIR_RIGHT) ? ror : rol;
    end else if (enable && !start) begin
      unique case (mode)
        MODE_HOLD:  q_d = q_q;
        MODE_LOAD:  q_d = D;
        MODE_SHL:   q_d = {q_q[WIDTH-2:0], sin_r};
        MODE_SHR:   q_d = {sin_l, q_q[WIDTH-1:1]};
        MODE_ROL:   q_d = rol;
        MODE_ROR:   q_d = ror;
        MODE_ASR:   q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        MODE_CLEAR: q_d = '0;
      endcase
    end
  end

  assign Q        = q_q;
  assign sout_msb = q_q[WIDTH-1];
  assign sout_lsb = q_q[0];
  assign zero     = (q_q == '0);

endmodule

// File: tb/tb_universal_shift_reg.sv
// Scoreboard bench: stimulus queues expected state,
// a monitor pops and compares on each check point.
module tb_universal_shift_reg;
  import shreg_pkg::*;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [2:0] mode;
  logic [7:0] D;
  logic       sin_l;
  logic       sin_r;
  logic       start;
  logic       dir;
  logic [3:0] amt;
  logic [7:0] Q;
  logic       sout_msb;
  logic       sout_lsb;
  logic       zero;
  logic       busy;
  logic       done;

  universal_shift_reg #(
    .WIDTH     (8),
    .RESET_VAL (8'h00)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .mode     (mode),
    .D        (D),
    .sin_l    (sin_l),
    .sin_r    (sin_r),
    .start    (start),
    .dir      (dir),
    .amt      (amt),
    .Q        (Q),
    .sout_msb (sout_msb),
    .sout_lsb (sout_lsb),
    .zero     (zero),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    int         cyc;
    string      nm;
    logic [7:0] q;
    logic       b;
    logic       d;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc    = 0;
  int   n_run  = 0;
  int   n_fail = 0;
  event chk_ev;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always begin
    @(negedge clk or chk_ev);
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_run++;
      if (Q !== e.q || busy !== e.b || done !== e.d ||
          zero !== (e.q == 8'h00) ||
          sout_msb !== e.q[7] || sout_lsb !== e.q[0]) begin
        n_fail++;
        $display("FAIL %s: got Q=%h busy=%b done=%b zero=%b msb=%b lsb=%b, want Q=%h busy=%b done=%b",
                 e.nm, Q, busy, done, zero, sout_msb, sout_lsb,
                 e.q, e.b, e.d);
      end
    end
  end

  task automatic push(input int at, input string nm,
                      input logic [7:0] q, input logic b,
                      input logic d);
    exp_t x;
    x.cyc = at;
    x.nm  = nm;
    x.q   = q;
    x.b   = b;
    x.d   = d;
    sb.push_back(x);
  endtask

  task automatic exp_next(input string nm, input logic [7:0] q,
                          input logic b, input logic d);
    push(cyc + 1, nm, q, b, d);
  endtask

  task automatic exp_now(input string nm, input logic [7:0] q,
                         input logic b, input logic d);
    push(cyc, nm, q, b, d);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic en, input logic [2:0] m,
                     input logic [7:0] d, input logic st,
                     input logic dr, input logic [3:0] am);
    enable = en;
    mode   = m;
    D      = d;
    start  = st;
    dir    = dr;
    amt    = am;
  endtask

  logic [7:0] rr [8];

  initial begin
    rr = '{8'hD2, 8'h69, 8'hB4, 8'h5A, 8'h2D, 8'h96, 8'h4B, 8'hA5};
    reset = 1'b0;
    sin_l = 1'b0;
    sin_r = 1'b0;
    drv(1'b1, MODE_LOAD, 8'h5A, 1'b0, DIR_LEFT, 4'd0);

    step();
    exp_now("rst_hold_a", 8'h00, 1'b0, 1'b0);
    step();
    exp_now("rst_hold_b", 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
    exp_next("load_5a", 8'h5A, 1'b0, 1'b0);
    step();

    drv(1'b1, MODE_LOAD, 8'hAA, 1'b0, DIR_LEFT, 4'd0);
    exp_next("load_aa", 8'hAA, 1'b0, 1'b0);
    step();
    drv(1'b0, MODE_LOAD, 8'hF0, 1'b0, DIR_LEFT, 4'd0);
    exp_next("hold_en0", 8'hAA, 1'b0, 1'b0);
    step();

    drv(1'b1, MODE_LOAD, 8'h81, 1'b0, DIR_LEFT, 4'd0);
    exp_next("load_81", 8'h81, 1'b0, 1'b0);
    step();
    sin_r = 1'b1;
    drv(1'b1, MODE_SHL, 8'h00, 1'b0, DIR_LEFT, 4'd0);
    exp_next("shl", 8'h03, 1'b0, 1'b0);
    step();
    sin_l = 1'b0;
    drv(1'b1, MODE_SHR, 8'h00, 1'b0, DIR_LEFT, 4'd0);
    exp_next("shr", 8'h01, 1'b0, 1'b0);
    step();
    drv(1'b1, MODE_LOAD, 8'h80, 1'b0, DIR_LEFT, 4'd0);
    exp_next("load_80", 8'h80, 1'b0, 1'b0);
    step();
    drv(1'b1, MODE_ASR, 8'h00, 1'b0, DIR_LEFT, 4'd0);
    exp_next("asr", 8'hC0, 1'b0, 1'b0);
    step();
    drv(1'b1, MODE_LOAD, 8'h01, 1'b0, DIR_LEFT, 4'd0);
    exp_next("load_01", 8'h01, 1'b0, 1'b0);
    step();
    drv(1'b1, MODE_ROR, 8'h00, 1'b0, DIR_LEFT, 4'd0);
    exp_next("ror", 8'h80, 1'b0, 1'b0);
    step();
    drv(1'b1, MODE_ROL, 8'h00, 1'b0, DIR_LEFT, 4'd0);
    exp_next("rol", 8'h01, 1'b0, 1'b0);
    step();
    drv(1'b1, MODE_CLEAR, 8'h00, 1'b0, DIR_LEFT, 4'd0);
    exp_next("clear", 8'h00, 1'b0, 1'b0);
    step();

    drv(1'b1, MODE_LOAD, 8'h81, 1'b0, DIR_LEFT, 4'd0);
    exp_next("load_81b", 8'h81, 1'b0, 1'b0);
    step();
    drv(1'b1, MODE_LOAD, 8'hFF, 1'b1, DIR_LEFT, 4'd3);
    exp_next("burst_go", 8'h81, 1'b1, 1'b0);
    step();
    drv(1'b1, MODE_CLEAR, 8'hFF, 1'b1, DIR_RIGHT, 4'd5);
    exp_next("burst_1", 8'h03, 1'b1, 1'b0);
    step();
    exp_next("burst_2", 8'h06, 1'b1, 1'b0);
    step();
    exp_next("burst_end", 8'h0C, 1'b0, 1'b1);
    step();
    drv(1'b0, MODE_HOLD, 8'h00, 1'b0, DIR_LEFT, 4'd0);
    exp_next("burst_post", 8'h0C, 1'b0, 1'b0);
    step();

    drv(1'b1, MODE_CLEAR, 8'h00, 1'b1, DIR_LEFT, 4'd0);
    exp_next("amt0_done", 8'h0C, 1'b0, 1'b1);
    step();
    drv(1'b0, MODE_HOLD, 8'h00, 1'b0, DIR_LEFT, 4'd0);
    exp_next("amt0_post", 8'h0C, 1'b0, 1'b0);
    step();

    drv(1'b1, MODE_LOAD, 8'hA5, 1'b0, DIR_LEFT, 4'd0);
    exp_next("load_a5", 8'hA5, 1'b0, 1'b0);
    step();
    drv(1'b1, MODE_HOLD, 8'h00, 1'b1, DIR_RIGHT, 4'd9);
    exp_next("clamp_go", 8'hA5, 1'b1, 1'b0);
    step();
    drv(1'b0, MODE_HOLD, 8'h00, 1'b0, DIR_LEFT, 4'd0);
    for (int i = 0; i < 8; i++) begin
      exp_next($sformatf("clamp_%0d", i), rr[i], i < 7, i == 7);
      step();
    end
    exp_next("clamp_post", 8'hA5, 1'b0, 1'b0);
    step();

    drv(1'b1, MODE_HOLD, 8'h00, 1'b1, DIR_LEFT, 4'd5);
    exp_next("mid_go", 8'hA5, 1'b1, 1'b0);
    step();
    drv(1'b0, MODE_HOLD, 8'h00, 1'b0, DIR_LEFT, 4'd0);
    exp_next("mid_1", 8'h4B, 1'b1, 1'b0);
    step();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    exp_now("mid_rst_async", 8'h00, 1'b0, 1'b0);
    ->chk_ev;
    step();
    exp_now("mid_rst_hold", 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
    exp_next("mid_no_done_a", 8'h00, 1'b0, 1'b0);
    step();
    exp_next("mid_no_done_b", 8'h00, 1'b0, 1'b0);
    step();
    step();

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d checks pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
